// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch unit and its branch
// target table.
//   - fetch_state_e : fetch sequencer states (IDLE, RUN, HALT)
//   - OPCODE_W      : opcode field width; the field sits in the top bits of
//                     the instruction word
//   - HALT_FILL     : fill bit for the default halt encoding (all-ones of any
//                     instruction width)
//   - lut_target()  : constant contents of the branch-target table
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  // The opcode occupies instruction bits [INST_W-1 -: OPCODE_W].
  localparam int OPCODE_W = 3;

  localparam int   DEFAULT_INST_W = 9;
  localparam logic HALT_FILL      = 1'b1;

  localparam int PERF_CNT_W = 16;

  // Branch-target table contents: entry i holds i*13+1. The caller truncates
  // the result to its PC width, so narrow PCs see the value modulo 2^PC_W.
  localparam int LUT_STRIDE = 13;
  localparam int LUT_BASE   = 1;

  function automatic int lut_target(input int idx);
    return idx * LUT_STRIDE + LUT_BASE;
  endfunction

endpackage

// File: rtl/branch_lut.sv
// branch_lut: constant branch-target table with 2^LUT_W entries of PC_W bits.
// The read is purely combinational.
// Ports:
//   target_idx in  LUT_W : table index
//   target_pc  out PC_W  : branch target PC stored at target_idx
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int LUT_W = 5
) (
  input  logic [LUT_W-1:0] target_idx,
  output logic [PC_W-1:0]  target_pc
);

  logic [PC_W-1:0] entries [2**LUT_W];

  for (genvar i = 0; i < 2**LUT_W; i++) begin : g_entry
    assign entries[i] = PC_W'(lut_target(i));
  end

  assign target_pc = entries[target_idx];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer for a small instruction ROM.
//
// A Start pulse launches a run from PC 0. Each unstalled RUN cycle the PC
// advances by one or is redirected to a branch-table target. The run stops in
// HALT either on the halt instruction or on PC overflow; overflow also raises
// the sticky Fault flag. Reset is synchronous and active-low.
//
// Optional build macro: FETCH_PERF_CNT_EN adds saturating RUN-cycle and
// taken-branch counters (CycleCnt, BranchCnt).
//
// Ports:
//   Clk          in  1          clock
//   Reset_n      in  1          synchronous active-low reset
//   Start        in  1          begin a run from PC 0 (ignored while running)
//   Stall        in  1          hold the PC this cycle
//   BranchTaken  in  1          redirect to LUT[TargetIdx] on the next edge
//   TargetIdx    in  LUT_W      branch-target table index
//   InstIn       in  INST_W     ROM read data at InstAddr
//   InstAddr     out PC_W       current PC
//   ALUOp        out 3          opcode of InstIn, 0 outside RUN
//   Valid        out 1          high in RUN
//   Done         out 1          high in HALT
//   Fault        out 1          sticky PC-overflow flag
//   CycleCnt     out 16         RUN cycles     (FETCH_PERF_CNT_EN only)
//   BranchCnt    out 16         taken branches (FETCH_PERF_CNT_EN only)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                PC_W      = 10,
  parameter int                INST_W    = DEFAULT_INST_W,
  parameter logic [INST_W-1:0] HALT_INST = {INST_W{HALT_FILL}},
  parameter int                LUT_W     = 5
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Stall,
  input  logic                BranchTaken,
  input  logic [LUT_W-1:0]    TargetIdx,
  input  logic [INST_W-1:0]   InstIn,
  output logic [PC_W-1:0]     InstAddr,
  output logic [OPCODE_W-1:0] ALUOp,
  output logic                Valid,
  output logic                Done,
  output logic                Fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] CycleCnt,
  output logic [PERF_CNT_W-1:0] BranchCnt
`endif
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [PC_W-1:0] branch_target;
  logic            advance;
  logic            is_halt;
  logic            pc_at_max;

  branch_lut #(
    .PC_W  (PC_W),
    .LUT_W (LUT_W)
  ) u_branch_lut (
    .target_idx (TargetIdx),
    .target_pc  (branch_target)
  );

  assign advance   = (state_q == ST_RUN) && !Stall;
  assign is_halt   = (InstIn == HALT_INST);
  assign pc_at_max = &pc_q;

  // Halt beats branch, and branch beats overflow: a branch from the last
  // address is legal, only a fall-through past it faults. Halting and
  // faulting both freeze the PC so the stop address stays visible.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fault_d = fault_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
          fault_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (advance) begin
          if (is_halt) begin
            state_d = ST_HALT;
          end else if (BranchTaken) begin
            pc_d = branch_target;
          end else if (pc_at_max) begin
            state_d = ST_HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
        fault_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fault_q <= fault_d;
    end
  end

  assign InstAddr = pc_q;
  assign Valid    = (state_q == ST_RUN);
  assign Done     = (state_q == ST_HALT);
  assign Fault    = fault_q;
  assign ALUOp    = Valid ? InstIn[INST_W-1 -: OPCODE_W] : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [PERF_CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  // A branch counts only when it actually redirects the PC, so a halt in
  // the same cycle suppresses it. Counters clear only when a Start is
  // accepted, which can happen only outside RUN.
  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (state_q != ST_RUN) begin
      if (Start) begin
        cycle_cnt_d  = '0;
        branch_cnt_d = '0;
      end
    end else begin
      if (cycle_cnt_q != '1) begin
        cycle_cnt_d = cycle_cnt_q + PERF_CNT_W'(1);
      end
      if (advance && !is_halt && BranchTaken && (branch_cnt_q != '1)) begin
        branch_cnt_d = branch_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      cycle_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign CycleCnt  = cycle_cnt_q;
  assign BranchCnt = branch_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. It runs two instances,
// a default 10-bit PC unit and a 4-bit PC unit that reaches overflow quickly.
// Both instances share the control inputs. Each instance reads its own ROM
// array. A behavioural model predicts every output after each clock edge.
module tb_fetch_unit;

  localparam int INST_W = 9;
  localparam int LUT_W  = 5;
  localparam logic [INST_W-1:0] HALT = 9'h1FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, start, stall, branch;
  logic [LUT_W-1:0]  idx;
  logic [INST_W-1:0] inst0, inst1;

  logic [9:0] addr0;
  logic [3:0] addr1;
  logic [2:0] aluop0, aluop1;
  logic       valid0, valid1, done0, done1, fault0, fault1;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cyc0, cyc1, brc0, brc1;
`endif

  fetch_unit #(.PC_W(10)) dut (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Stall(stall),
    .BranchTaken(branch), .TargetIdx(idx), .InstIn(inst0),
    .InstAddr(addr0), .ALUOp(aluop0), .Valid(valid0), .Done(done0),
    .Fault(fault0)
`ifdef FETCH_PERF_CNT_EN
    , .CycleCnt(cyc0), .BranchCnt(brc0)
`endif
  );

  fetch_unit #(.PC_W(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .Start(start), .Stall(stall),
    .BranchTaken(branch), .TargetIdx(idx), .InstIn(inst1),
    .InstAddr(addr1), .ALUOp(aluop1), .Valid(valid1), .Done(done1),
    .Fault(fault1)
`ifdef FETCH_PERF_CNT_EN
    , .CycleCnt(cyc1), .BranchCnt(brc1)
`endif
  );

  // Reference model state, one slot per instance.
  logic [INST_W-1:0] rom [2][1024];
  bit m_run [2];
  bit m_halt [2];
  bit m_fault [2];
  int m_pc [2];
  int m_cyc [2];
  int m_br [2];
  int pc_max [2] = '{1023, 15};

  int check_count = 0;
  int pass_count  = 0;
  int fail_count  = 0;

  // Table entry i is i*13+1, wrapped to the instance's PC range.
  function automatic int lutTarget(input int u, input int ti);
    return (ti * 13 + 1) % (pc_max[u] + 1);
  endfunction

  // Advance the model of instance u by one rising edge.
  task automatic modelEdge(input int u, input logic [INST_W-1:0] inst);
    if (!rst_n) begin
      m_run[u] = 0; m_halt[u] = 0; m_fault[u] = 0;
      m_pc[u] = 0; m_cyc[u] = 0; m_br[u] = 0;
    end else if (!m_run[u]) begin
      if (start) begin
        m_run[u] = 1; m_halt[u] = 0; m_fault[u] = 0;
        m_pc[u] = 0; m_cyc[u] = 0; m_br[u] = 0;
      end
    end else begin
      if (m_cyc[u] < 65535) m_cyc[u]++;
      if (!stall) begin
        if (inst == HALT) begin
          m_run[u] = 0; m_halt[u] = 1;
        end else if (branch) begin
          m_pc[u] = lutTarget(u, int'(idx));
          if (m_br[u] < 65535) m_br[u]++;
        end else if (m_pc[u] == pc_max[u]) begin
          m_run[u] = 0; m_halt[u] = 1; m_fault[u] = 1;
        end else begin
          m_pc[u]++;
        end
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    check_count++;
    assert (obs === exp) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    checkOutput("u0.InstAddr", 32'(addr0), 32'(m_pc[0]));
    checkOutput("u0.Valid", 32'(valid0), 32'(m_run[0]));
    checkOutput("u0.Done", 32'(done0), 32'(m_halt[0]));
    checkOutput("u0.Fault", 32'(fault0), 32'(m_fault[0]));
    checkOutput("u0.ALUOp", 32'(aluop0), m_run[0] ? 32'(inst0 >> 6) : 32'd0);
    checkOutput("u1.InstAddr", 32'(addr1), 32'(m_pc[1]));
    checkOutput("u1.Valid", 32'(valid1), 32'(m_run[1]));
    checkOutput("u1.Done", 32'(done1), 32'(m_halt[1]));
    checkOutput("u1.Fault", 32'(fault1), 32'(m_fault[1]));
    checkOutput("u1.ALUOp", 32'(aluop1), m_run[1] ? 32'(inst1 >> 6) : 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("u0.CycleCnt", 32'(cyc0), 32'(m_cyc[0]));
    checkOutput("u0.BranchCnt", 32'(brc0), 32'(m_br[0]));
    checkOutput("u1.CycleCnt", 32'(cyc1), 32'(m_cyc[1]));
    checkOutput("u1.BranchCnt", 32'(brc1), 32'(m_br[1]));
`endif
  endtask

  // Drive one cycle of inputs, clock it, update the model, present the ROM
  // word at the new PC, and compare every output.
  task automatic applyStimulus(input logic rn, input logic s, input logic st,
                               input logic b, input logic [LUT_W-1:0] ti);
    rst_n = rn; start = s; stall = st; branch = b; idx = ti;
    inst0 = rom[0][m_pc[0]];
    inst1 = rom[1][m_pc[1]];
    @(posedge clk);
    modelEdge(0, inst0);
    modelEdge(1, inst1);
    #1;
    inst0 = rom[0][m_pc[0]];
    inst1 = rom[1][m_pc[1]];
    #1;
    checkAll();
  endtask

  task automatic fillRom(input int halt_pct);
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 1024; i++)
        rom[u][i] = ($urandom_range(0, 99) < halt_pct) ? HALT
                    : INST_W'($urandom_range(0, 510));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0; branch = 1'b0; idx = '0;
    fillRom(0);
    for (int u = 0; u < 2; u++) begin
      m_run[u] = 0; m_halt[u] = 0; m_fault[u] = 0;
      m_pc[u] = 0; m_cyc[u] = 0; m_br[u] = 0;
    end

    // Reset state.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset.InstAddr", 32'(addr0), 32'd0);
    checkOutput("reset.Valid", 32'(valid0), 32'd0);
    checkOutput("reset.Done", 32'(done0), 32'd0);
    checkOutput("reset.ALUOp", 32'(aluop0), 32'd0);

    // Sequential fetch from PC 0.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("seq.pc0", 32'(addr0), 32'd0);
    checkOutput("seq.valid", 32'(valid0), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1, 0, 0, 0, 0);
      checkOutput("seq.pc", 32'(addr0), 32'(k));
    end
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    // Stall wins over a branch, then the branch redirects to LUT[3].
    applyStimulus(1, 0, 1, 1, 3);
    checkOutput("stall.hold", 32'(addr0), 32'd5);
    applyStimulus(1, 0, 0, 1, 3);
    checkOutput("branch.target", 32'(addr0), 32'd40);
    checkOutput("branch.target4", 32'(addr1), 32'd8);

    // Start while running is ignored.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("start.ignored", 32'(addr0), 32'd41);

    // Halt instruction at PC 7.
    rom[0][7] = HALT;
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 2);
    checkOutput("halt.done", 32'(done0), 32'd1);
    checkOutput("halt.addr", 32'(addr0), 32'd7);
    checkOutput("halt.valid", 32'(valid0), 32'd0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("halt.hold", 32'(addr0), 32'd7);
    rom[0][7] = 9'h0AA;
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("halt.restart", 32'(addr0), 32'd0);
    checkOutput("halt.rerun", 32'(valid0), 32'd1);

    // Reset in the middle of a run at PC 9.
    for (int k = 0; k < 9; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midreset.pc9", 32'(addr0), 32'd9);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("midreset.pc", 32'(addr0), 32'd0);
    checkOutput("midreset.valid", 32'(valid0), 32'd0);
    checkOutput("midreset.done", 32'(done0), 32'd0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("midreset.rerun", 32'(addr0), 32'd1);

    // 4-bit PC runs off the end: HALT with Fault, then Start clears it.
    for (int k = 0; k < 14; k++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ovf.pc15", 32'(addr1), 32'd15);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("ovf.fault", 32'(fault1), 32'd1);
    checkOutput("ovf.done", 32'(done1), 32'd1);
    checkOutput("ovf.hold", 32'(addr1), 32'd15);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("ovf.clear", 32'(fault1), 32'd0);
    checkOutput("ovf.restart", 32'(addr1), 32'd0);

    // Ten RUN cycles with two taken branches and one stall.
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 10; k++)
      applyStimulus(1, 0, (k == 5), (k == 2 || k == 7),
                    LUT_W'($urandom_range(0, 31)));
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf.cycles", 32'(cyc0), 32'd10);
    checkOutput("perf.branches", 32'(brc0), 32'd2);
`endif

    // Randomised traffic against the model, with halts in the ROMs.
    fillRom(4);
    for (int k = 0; k < 600; k++)
      applyStimulus(($urandom_range(0, 99) >= 2),
                    ($urandom_range(0, 99) < 8),
                    ($urandom_range(0, 99) < 25),
                    ($urandom_range(0, 99) < 20),
                    LUT_W'($urandom_range(0, 31)));

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
